// File: rtl/rv32_pkg.sv
// Shared RV32I encoding types, opcode constants and range helpers.
package rv32_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OPIMM  = 7'h13;
  localparam logic [6:0] OP_OP     = 7'h33;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // True when every bit above 'top' equals bit 'top', i.e. the value is a
  // correctly sign-extended (top+1)-bit two's complement number.
  function automatic logic imm_fits(input logic [31:0] imm, input int unsigned top);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i > int'(top)) && (imm[i] != imm[top])) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/instruction_encoder_imm_packer.sv
// Combinational packer: decoded fields plus immediate -> 32-bit RV32I word,
// with a flag when the immediate cannot be represented in its format.
module imm_packer
  import rv32_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  // Select the bit layout for the format and apply its range rule.
  always_comb begin
    instr = NOP;
    err   = 1'b1;
    case (fmt)
      FMT_R: begin
        instr = {funct7, rs2, rs1, funct3, rd, opcode};
        err   = 1'b0;
      end
      FMT_I: begin
        instr = {imm[11:0], rs1, funct3, rd, opcode};
        err   = !imm_fits(imm, 11);
      end
      FMT_S: begin
        instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err   = !imm_fits(imm, 11);
      end
      FMT_B: begin
        instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err   = !imm_fits(imm, 12) || imm[0];
      end
      FMT_U: begin
        instr = {imm[31:12], rd, opcode};
        err   = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err   = !imm_fits(imm, 20) || imm[0];
      end
      default: begin
        instr = NOP;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instruction_encoder.sv
// Streams a programmed number of encoded RV32I words to sequential word
// addresses through a single registered valid/ready output stage.
module instruction_encoder
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_instr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_err_q, out_err_d;

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        accept;
  logic        out_hs;

  imm_packer u_packer (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .instr  (pack_instr),
    .err    (pack_err)
  );

  assign in_ready  = (state_q == ST_RUN) && (remaining_q != '0) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_hs    = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_addr  = out_addr_q;
  assign out_err   = out_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign err_count = err_count_q;

  // Next-state, counters and output-stage load/drain.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    err_count_d = err_count_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;

    // A drained word frees the stage; a same-cycle accept refills it below.
    if (out_hs) out_valid_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = num_instr;
          err_count_d = '0;
          state_d     = (num_instr == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_instr_d = pack_instr;
          out_addr_d  = addr_q;
          out_err_d   = pack_err;
          addr_d      = addr_q + ADDR_W'(4);
          remaining_d = remaining_q - CNT_W'(1);
          if (pack_err && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q || out_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset clears everything including the
  // pending output so an aborted run leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      err_count_q <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      err_count_q <= err_count_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_addr_q  <= out_addr_d;
      out_err_q   <= out_err_d;
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: expected words are queued at
// input accept and compared when the output handshake occurs.
module tb_instruction_encoder;
  import rv32_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] num_instr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic        out_err;
  logic        busy;
  logic        done;
  logic [15:0] err_count;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  logic [31:0] exp_addr;

  instruction_encoder #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_instr(num_instr),
    .in_valid(in_valid), .in_ready(in_ready), .in_fmt(in_fmt), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
    .in_funct7(in_funct7), .in_imm(in_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .out_err(out_err), .busy(busy),
    .done(done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got instr=%h addr=%h, expected no word", out_instr, out_addr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_instr !== e.instr || out_addr !== e.addr || out_err !== e.err) begin
            errors++;
            $display("FAIL out_word got instr=%h addr=%h err=%b expected instr=%h addr=%h err=%b",
                     out_instr, out_addr, out_err, e.instr, e.addr, e.err);
          end
        end
      end
    end
  endtask

  task automatic do_start(input logic [31:0] base, input logic [15:0] num);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_instr = num;
    exp_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] exp_instr, input logic exp_err, output int waited);
    logic accepted;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_valid = 1'b1;
    waited = 0; accepted = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{instr: exp_instr, addr: exp_addr, err: exp_err});
        exp_addr = exp_addr + 32'd4;
        accepted = 1'b1;
        break;
      end
      waited++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!accepted) begin
      checks++; errors++;
      $display("FAIL send_timeout got no in_ready in 50 cycles, expected accept of %h", exp_instr);
    end
  endtask

  task automatic wait_done(input int max_cycles, output int cyc);
    logic got;
    cyc = 0; got = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      cyc++;
      if (done) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout got no done in %0d cycles, expected a pulse", max_cycles);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got done=%b busy=%b after pulse, expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got busy=%b done=%b in_ready=%b out_valid=%b, expected 0 0 0 0",
               busy, done, in_ready, out_valid);
    end
    checks++;
    if (out_instr !== 32'h0 || out_addr !== 32'h0 || out_err !== 1'b0 || err_count !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got instr=%h addr=%h err=%b cnt=%0d, expected 0 0 0 0",
               out_instr, out_addr, out_err, err_count);
    end
  endtask

  task automatic test_idle_ignore();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL idle_in_ready got %b, expected 0", in_ready);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_single();
    int w, cyc;
    out_ready = 1'b1;
    do_start(32'h100, 16'd1);
    send(3'(FMT_I), OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, w);
    wait_done(20, cyc);
    checks++;
    if (cyc != 2) begin
      errors++;
      $display("FAIL single_done_latency got %0d cycles, expected 2", cyc);
    end
  endtask

  task automatic test_back_to_back();
    int w[4];
    int cyc;
    out_ready = 1'b1;
    do_start(32'h100, 16'd4);
    // A start pulse during the run must not disturb it.
    start = 1'b1; base_addr = 32'h500; num_instr = 16'd9;
    send(3'(FMT_S), OP_STORE,  5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         32'h0020_A423, 1'b0, w[0]);
    send(3'(FMT_B), OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 1'b0, w[1]);
    send(3'(FMT_U), OP_LUI,    5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0, w[2]);
    send(3'(FMT_J), OP_JAL,    5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0,         32'h0000_006F, 1'b0, w[3]);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (w[i] != 0) begin
        errors++;
        $display("FAIL b2b_stall word %0d waited %0d cycles, expected 0", i, w[i]);
      end
    end
    wait_done(20, cyc);
    checks++;
    if (err_count !== 16'd0) begin
      errors++;
      $display("FAIL b2b_err_count got %0d, expected 0", err_count);
    end
  endtask

  task automatic test_stall();
    int cyc;
    out_ready = 1'b1;
    do_start(32'h200, 16'd3);
    fork
      begin
        int w;
        send(3'(FMT_I), OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0093, 1'b0, w);
        send(3'(FMT_I), OP_OPIMM, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0113, 1'b0, w);
        send(3'(FMT_R), OP_OP,    5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h4020_81B3, 1'b0, w);
      end
      begin
        logic [31:0] held_i, held_a;
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
          @(posedge clk); #1;
          if (out_valid) begin seen = 1'b1; break; end
        end
        out_ready = 1'b0;
        held_i = out_instr; held_a = out_addr;
        checks++;
        if (!seen) begin
          errors++;
          $display("FAIL stall_no_output got out_valid=0 for 20 cycles, expected 1");
        end
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checks++;
          if (out_instr !== held_i || out_addr !== held_a || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got instr=%h addr=%h vld=%b rdy=%b, expected %h %h 1 0",
                     out_instr, out_addr, out_valid, in_ready, held_i, held_a);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_done(20, cyc);
  endtask

  task automatic test_errors();
    int w, cyc;
    out_ready = 1'b1;
    do_start(32'h400, 16'd3);
    send(3'(FMT_I), OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h8000_0093, 1'b1, w);
    checks++;
    if (err_count !== 16'd1) begin
      errors++; $display("FAIL err_count_i got %0d, expected 1", err_count);
    end
    send(3'(FMT_B), OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0000_0163, 1'b1, w);
    checks++;
    if (err_count !== 16'd2) begin
      errors++; $display("FAIL err_count_b got %0d, expected 2", err_count);
    end
    send(3'd7, OP_OPIMM, 5'd4, 5'd4, 5'd4, 3'd1, 7'd0, 32'd0, NOP, 1'b1, w);
    checks++;
    if (err_count !== 16'd3) begin
      errors++; $display("FAIL err_count_fmt got %0d, expected 3", err_count);
    end
    wait_done(20, cyc);
    checks++;
    if (err_count !== 16'd3) begin
      errors++; $display("FAIL err_count_hold got %0d after done, expected 3", err_count);
    end
  endtask

  task automatic test_zero_count();
    do_start(32'h300, 16'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL zero_done got done=%b busy=%b, expected 1 1", done, busy);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err_count !== 16'd0) begin
      errors++;
      $display("FAIL zero_after got done=%b busy=%b cnt=%0d, expected 0 0 0", done, busy, err_count);
    end
  endtask

  task automatic test_wrap();
    int w, cyc;
    out_ready = 1'b1;
    do_start(32'hFFFF_FFFC, 16'd2);
    send(3'(FMT_I), OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 1'b0, w);
    send(3'(FMT_J), OP_JAL,   5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800, 32'h0010_00EF, 1'b0, w);
    wait_done(20, cyc);
  endtask

  task automatic test_rst_mid_run();
    int w;
    out_ready = 1'b0;
    do_start(32'h600, 16'd4);
    send(3'(FMT_I), OP_OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0, w);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || out_instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_run got busy=%b vld=%b rdy=%b instr=%h, expected 0 0 0 0",
               busy, out_valid, in_ready, out_instr);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL rst_no_done got done=%b, expected 0", done);
      end
    end
    out_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; num_instr = '0; in_valid = 1'b0;
    in_fmt = '0; in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0; out_ready = 1'b0;
    checks = 0; errors = 0; exp_addr = '0;
    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog got no completion by 200000, expected finish");
        $fatal(1, "watchdog");
      end
    join_none
    test_reset();
    test_idle_ignore();
    test_single();
    test_back_to_back();
    test_stall();
    test_errors();
    test_zero_count();
    test_wrap();
    test_rst_mid_run();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d pending words, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
